// File: rtl/alu_result_serializer_if.sv
// alu_result_serializer_if: ALU result capture side and narrow beat stream side
interface alu_result_serializer_if #(parameter int OUT_W = 32);
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_result;
  logic             in_carry;
  logic             in_op;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
  logic             out_op;
  logic             out_carry;
  modport master (
    output in_valid, in_result, in_carry, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_op, out_carry
  );
  modport slave (
    input  in_valid, in_result, in_carry, in_op, out_ready,
    output in_ready, out_valid, out_data, out_last, out_op, out_carry
  );
endinterface

// File: rtl/alu_result_serializer.sv
// alu_result_serializer: buffers ALU results in a FIFO and streams them out as OUT_W-bit beats
module alu_result_serializer #(
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  alu_result_serializer_if.slave bus,
  output logic                  busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] LAST_ADD = 2'(32 / OUT_W - 1);
  localparam logic [1:0] LAST_MUL = 2'(64 / OUT_W - 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t            state, state_n;
  logic [65:0]       mem [DEPTH];
  logic [AW-1:0]     wr, rd;
  logic [AW:0]       count, count_n;
  logic [1:0]        idx, idx_n;
  logic [65:0]       entry, nxt;
  logic [63:0]       res;
  logic [OUT_W-1:0]  data_n;
  logic              push, pop, fire, load, adv, last_n;
  assign bus.in_ready  = rst_n && count < (AW+1)'(DEPTH);
  assign bus.out_valid = state == SEND;
  assign push = bus.in_valid && bus.in_ready;
  assign fire = state == SEND && bus.out_ready;
  assign pop  = fire && bus.out_last;
  assign adv  = fire && !bus.out_last;
  assign load = (state == IDLE && count != '0) || (pop && (count > (AW+1)'(1) || push));
  // With one entry left, the follower is the one being pushed this cycle; bypass it to avoid a bubble
  assign nxt = count == (AW+1)'(1) ? {bus.in_result, bus.in_carry & ~bus.in_op, bus.in_op} : mem[rd + AW'(1)];
  always_comb begin
    entry   = pop ? nxt : mem[rd];
    idx_n   = adv ? idx + 2'd1 : 2'd0;
    res     = entry[65:2];
    data_n  = res[32'(idx_n) * OUT_W +: OUT_W];
    last_n  = idx_n == (entry[0] ? LAST_MUL : LAST_ADD);
    state_n = (load || (state == SEND && !pop)) ? SEND : IDLE;
    count_n = count + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr] <= {bus.in_result, bus.in_carry & ~bus.in_op, bus.in_op};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      count         <= '0;
      wr            <= '0;
      rd            <= '0;
      idx           <= '0;
      busy          <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      bus.out_op    <= 1'b0;
      bus.out_carry <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      wr    <= wr + AW'(push);
      rd    <= rd + AW'(pop);
      busy  <= count_n != '0;
      if (load || adv) begin
        idx           <= idx_n;
        bus.out_data  <= data_n;
        bus.out_last  <= last_n;
        bus.out_op    <= entry[0];
        bus.out_carry <= entry[1];
      end else if (state_n == IDLE) begin
        idx           <= '0;
        bus.out_data  <= '0;
        bus.out_last  <= 1'b0;
        bus.out_op    <= 1'b0;
        bus.out_carry <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_result_serializer.sv
// tb_alu_result_serializer: directed steps with a beat scoreboard for 32- and 16-bit instances
module tb_alu_result_serializer;
  typedef struct packed {logic [31:0] d; logic l; logic o; logic c;} beat_t;
  logic clk = 1'b0;
  logic rst_a, rst_b, busy_a, busy_b;
  int checks = 0;
  int failures = 0;
  beat_t q32[$];
  beat_t q16[$];
  alu_result_serializer_if #(.OUT_W(32)) a ();
  alu_result_serializer_if #(.OUT_W(16)) b ();
  alu_result_serializer #(.OUT_W(32), .DEPTH(2)) dut_a (.clk(clk), .rst_n(rst_a), .bus(a), .busy(busy_a));
  alu_result_serializer #(.OUT_W(16), .DEPTH(2)) dut_b (.clk(clk), .rst_n(rst_b), .bus(b), .busy(busy_b));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic expect_beats(input int w, input logic [63:0] r, input logic c, input logic op);
    beat_t bt;
    int n;
    n = (op ? 64 : 32) / w;
    for (int k = 0; k < n; k++) begin
      bt.d = 32'((r >> (k * w)) & ((64'd1 << w) - 64'd1));
      bt.l = k == n - 1;
      bt.o = op;
      bt.c = c & ~op;
      if (w == 32) q32.push_back(bt);
      else q16.push_back(bt);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_a(input logic [63:0] r, input logic c, input logic op);
    a.in_valid = 1'b1; a.in_result = r; a.in_carry = c; a.in_op = op;
    for (int i = 0; i < 20 && !a.in_ready; i++) tick();
    chk("a_accept", 64'(a.in_ready), 64'd1);
    if (a.in_ready) expect_beats(32, r, c, op);
    tick();
    a.in_valid = 1'b0;
  endtask
  task automatic send_b(input logic [63:0] r, input logic c, input logic op);
    b.in_valid = 1'b1; b.in_result = r; b.in_carry = c; b.in_op = op;
    for (int i = 0; i < 20 && !b.in_ready; i++) tick();
    chk("b_accept", 64'(b.in_ready), 64'd1);
    if (b.in_ready) expect_beats(16, r, c, op);
    tick();
    b.in_valid = 1'b0;
  endtask
  task automatic drain_a();
    for (int i = 0; i < 30 && (q32.size() != 0 || a.out_valid || busy_a); i++) tick();
    chk("a_drain", 64'({q32.size() == 0, a.out_valid, busy_a}), 64'b100);
  endtask
  always @(negedge clk) begin : mon_a
    beat_t e;
    if (rst_a === 1'b1 && a.out_valid === 1'b1 && a.out_ready === 1'b1) begin
      if (q32.size() == 0) chk("a_unexpected_beat", 64'(a.out_data), 64'hx);
      else begin
        e = q32.pop_front();
        chk("a_beat", 64'({a.out_data, a.out_last, a.out_op, a.out_carry}), 64'(e));
      end
    end
  end
  always @(negedge clk) begin : mon_b
    beat_t e;
    if (rst_b === 1'b1 && b.out_valid === 1'b1 && b.out_ready === 1'b1) begin
      if (q16.size() == 0) chk("b_unexpected_beat", 64'(b.out_data), 64'hx);
      else begin
        e = q16.pop_front();
        chk("b_beat", 64'({16'h0, b.out_data, b.out_last, b.out_op, b.out_carry}), 64'(e));
      end
    end
  end
  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    a.in_valid = 1'b1; a.in_result = 64'h5555_6666_7777_8888; a.in_carry = 1'b1; a.in_op = 1'b0; a.out_ready = 1'b1;
    b.in_valid = 1'b1; b.in_result = 64'h1; b.in_carry = 1'b0; b.in_op = 1'b1; b.out_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("a_reset", 64'({a.out_valid, a.out_data, a.out_last, a.out_op, a.out_carry, busy_a, a.in_ready}), 64'd0);
      chk("b_reset", 64'({b.out_valid, b.out_data, b.out_last, b.out_op, b.out_carry, busy_b, b.in_ready}), 64'd0);
    end
    a.in_valid = 1'b0; b.in_valid = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
    tick();
    chk("a_post_reset", 64'({a.in_ready, a.out_valid, busy_a}), 64'b100);
    chk("b_post_reset", 64'({b.in_ready, b.out_valid, busy_b}), 64'b100);
    // single add: first beat two edges after the push
    send_a(64'h0000_0001_FFFF_FFFE, 1'b1, 1'b0);
    chk("add_latency_n", 64'(a.out_valid), 64'd0);
    tick();
    chk("add_beat", 64'({a.out_valid, a.out_data, a.out_last, a.out_op, a.out_carry}), 64'({1'b1, 32'hFFFF_FFFE, 3'b101}));
    tick();
    chk("add_idle", 64'({a.out_valid, busy_a}), 64'd0);
    drain_a();
    // multiply held under backpressure
    a.out_ready = 1'b0;
    send_a(64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1);
    tick();
    repeat (4) begin
      chk("mul_hold", 64'({a.out_valid, a.out_data, a.out_last, a.out_op, a.out_carry}), 64'({1'b1, 32'h9ABC_DEF0, 3'b010}));
      tick();
    end
    a.out_ready = 1'b1;
    tick();
    chk("mul_last", 64'({a.out_valid, a.out_data, a.out_last, a.out_op, a.out_carry}), 64'({1'b1, 32'h1234_5678, 3'b110}));
    tick();
    chk("mul_idle", 64'(a.out_valid), 64'd0);
    drain_a();
    // fill the FIFO with three multiplies
    a.out_ready = 1'b0;
    a.in_valid = 1'b1; a.in_op = 1'b1; a.in_carry = 1'b0;
    a.in_result = 64'h1111_1111_0000_0001;
    chk("full_rdy1", 64'(a.in_ready), 64'd1);
    expect_beats(32, a.in_result, 1'b0, 1'b1);
    tick();
    a.in_result = 64'h2222_2222_0000_0002;
    chk("full_rdy2", 64'(a.in_ready), 64'd1);
    expect_beats(32, a.in_result, 1'b0, 1'b1);
    tick();
    a.in_result = 64'h3333_3333_0000_0003;
    chk("full_rdy3", 64'(a.in_ready), 64'd0);
    repeat (2) begin
      tick();
      chk("full_wait", 64'({a.in_ready, busy_a, a.out_valid}), 64'b011);
    end
    a.out_ready = 1'b1;
    tick();
    chk("full_still", 64'(a.in_ready), 64'd0);
    tick();
    chk("full_freed", 64'(a.in_ready), 64'd1);
    if (a.in_ready) expect_beats(32, a.in_result, 1'b0, 1'b1);
    tick();
    a.in_valid = 1'b0;
    drain_a();
    // push on the same edge as the last beat of the only entry
    send_a(64'hFFFF_0000_DEAD_BEEF, 1'b0, 1'b0);
    tick();
    chk("sim_first", 64'({a.out_valid, a.out_data, busy_a}), 64'({1'b1, 32'hDEAD_BEEF, 1'b1}));
    send_a(64'h0000_0000_1234_5678, 1'b1, 1'b0);
    chk("sim_next", 64'({a.out_valid, a.out_data, a.out_last, a.out_carry, busy_a, a.in_ready}), 64'({1'b1, 32'h1234_5678, 4'b1111}));
    tick();
    chk("sim_idle", 64'({a.out_valid, busy_a}), 64'd0);
    drain_a();
    // 16-bit multiply interrupted by reset after two beats
    send_b(64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 1'b1);
    chk("b_latency_n", 64'(b.out_valid), 64'd0);
    tick();
    chk("b_beat0", 64'({b.out_data, b.out_last}), 64'({16'hDDDD, 1'b0}));
    tick();
    chk("b_beat1", 64'({b.out_data, b.out_last}), 64'({16'hCCCC, 1'b0}));
    tick();
    chk("b_beat2", 64'({b.out_valid, b.out_data, b.out_last}), 64'({1'b1, 16'hBBBB, 1'b0}));
    rst_b = 1'b0; b.out_ready = 1'b0;
    chk("b_consumed", 64'(q16.size()), 64'd2);
    q16.delete();
    tick();
    chk("b_mid_reset", 64'({b.out_valid, b.out_data, b.out_last, b.out_op, b.out_carry, busy_b, b.in_ready}), 64'd0);
    rst_b = 1'b1; b.out_ready = 1'b1;
    tick();
    chk("b_after_reset", 64'({b.out_valid, busy_b, b.in_ready}), 64'b001);
    send_b(64'h9999_8888_1111_2222, 1'b1, 1'b0);
    tick();
    chk("b_add0", 64'({b.out_valid, b.out_data, b.out_last, b.out_op, b.out_carry}), 64'({1'b1, 16'h2222, 3'b001}));
    tick();
    chk("b_add1", 64'({b.out_valid, b.out_data, b.out_last, b.out_op, b.out_carry}), 64'({1'b1, 16'h1111, 3'b101}));
    repeat (3) tick();
    chk("b_drain", 64'({q16.size() == 0, b.out_valid, busy_b}), 64'b100);
    chk("a_final_empty", 64'(q32.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_result_serializer.md
# alu_result_serializer

Registered output stage directly downstream of the combinational add/multiply ALU. Captures each ALU result (64-bit value, carry, operation select) into a small FIFO and streams it out as narrow words over a valid/ready interface. Add results produce one word and multiply results produce the full 64 bits, low word first. This decouples the single-cycle ALU from slower consumers and provides the design's first clocked result boundary.

## Interface
- `OUT_W`, 32, output word width; legal values 16 or 32.
- `DEPTH`, 2, result FIFO depth in entries; power of two, at least 2.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  ALU result is present.
- `in_ready`  out  1  a FIFO slot is free.
- `in_result`  in  64  ALU output value.
- `in_carry`  in  1  adder carry-out; ignored when `in_op` = 1.
- `in_op`  in  1  0 = add, 1 = multiply.
- `out_valid`  out  1  `out_data` holds a valid beat.
- `out_ready`  in  1  consumer accepts the beat.
- `out_data`  out  OUT_W  current beat.
- `out_last`  out  1  final beat of the current entry.
- `out_op`  out  1  operation of the current entry.
- `out_carry`  out  1  carry of the current entry; forced to 0 for multiply.
- `busy`  out  1  FIFO non-empty or a beat is pending.

## Operation
- **Push:** an entry `{in_result, in_carry & ~in_op, in_op}` is written when `in_valid & in_ready`.
  - `in_ready` = (count < DEPTH) and is held 0 while `rst_n` is low.
  - A full FIFO does not accept a push in the same cycle it pops; the freed slot is visible on the next cycle.
- **Beats per entry:**
  - Add: 32/OUT_W beats covering bits [31:0] only. The upper 32 bits are discarded, not checked.
  - Multiply: 64/OUT_W beats.
  - Beat k carries bits [k·OUT_W +: OUT_W], starting at k = 0.
- **State machine:**
  - `IDLE`: out_valid = 0. Go to `SEND` when the FIFO is non-empty, loading beat index 0 from the head entry.
  - `SEND`: out_valid = 1.
    - On `out_ready` with a beat that is not last: increment the beat index and stay in `SEND`.
    - On `out_ready` with the last beat: pop the head entry. Go to `SEND` with index 0 of the next entry if one remains, otherwise go to `IDLE`.
- `out_last` = 1 when beat index = beats(op) − 1.
- `out_op` and `out_carry` are constant across all beats of an entry.
- While `out_valid & ~out_ready`, all outputs hold stable.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and FIFO order is preserved.
- `busy` = (count ≠ 0).

## Timing
- **Reset:** when `rst_n` = 0 at a clock edge, the following are cleared: count, read/write pointers, beat index, state = `IDLE`, out_valid = 0, out_data = 0, out_last = 0, out_op = 0, out_carry = 0, busy = 0.
  - Reset mid-burst discards all entries and any partial beat.
  - `in_ready` returns to 1 on the first cycle after `rst_n` goes high.
- **Latency:** an entry pushed at edge N presents its first beat with out_valid = 1 after edge N+1, provided the FIFO was empty and idle. The path is not combinational from in to out.
- **Throughput:** one beat per cycle under continuous `out_ready`, with no bubble between entries.
  - With OUT_W = 32, sustained input is 1 add per cycle or 1 multiply per 2 cycles.
- All outputs are registered except `in_ready`, which is decoded from the registered count.

## Test plan
- **Reset:** hold `rst_n` low 3 cycles with `in_valid` = 1 → all outputs 0 and `in_ready` = 0 during reset; `in_ready` = 1 the cycle after release; no entry captured.
- **Single add, OUT_W = 32:** push add `in_result` = 0x0000_0001_FFFF_FFFE, carry = 1, `out_ready` = 1 → one beat 0xFFFF_FFFE with last = 1, op = 0, carry = 1, two cycles after push.
- **Multiply with backpressure:** push 0x1234_5678_9ABC_DEF0, op = 1, carry = 1; hold `out_ready` = 0 for 4 cycles → 0x9ABC_DEF0 held stable with last = 0, carry = 0. Then `out_ready` = 1 → 0x1234_5678 with last = 1; then IDLE.
- **Full FIFO:** push 3 multiplies back-to-back with `out_ready` = 0 → `in_ready` drops after 2 pushes and the third waits. Release `out_ready` → 6 beats in order, third entry accepted the cycle after the first pop, `busy` falls after the last beat.
- **Simultaneous push/pop:** count = 1, push on the same edge as the last beat is accepted → count stays 1, next entry streams with no bubble.
- **OUT_W = 16 and reset mid-burst:** multiply 0xAAAA_BBBB_CCCC_DDDD → beats DDDD, CCCC, BBBB, AAAA with last on the 4th. Assert `rst_n` = 0 after the 2nd beat → remaining beats dropped and outputs cleared.
